ram_port_bridge: RTL and testbench

// - Sits between the sd_host RAM port (ADMA side) and the system memory bus, downstream of the DMA engine.
// - Queues DMA read/write strobes in a small command FIFO and replays them as req/gnt transactions.
// - Returns read data with a one-cycle valid pulse and asserts STOP as back-pressure to the host core.

---
 rtl/ram_port_bridge_pkg.sv | 27 ++
 rtl/ram_port_bridge_if.sv | 41 ++++
 rtl/ram_port_bridge_cmd_fifo.sv | 63 ++++++
 rtl/ram_port_bridge.sv | 196 +++++++++++++++++++
 tb/tb_ram_port_bridge.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_bridge_pkg.sv
// Shared types and defaults for the sd_host RAM port to memory bus bridge.
package ram_port_bridge_pkg;

  localparam int unsigned RPB_ADDR_W  = 64;
  localparam int unsigned RPB_DATA_W  = 32;
  localparam int unsigned RPB_DEPTH   = 4;
  localparam int unsigned RPB_TIMEOUT = 255;

  localparam int unsigned ERR_CONFLICT = 0;
  localparam int unsigned ERR_OVERFLOW = 1;
  localparam int unsigned ERR_TIMEOUT  = 2;
  localparam int unsigned ERR_W        = 3;

  typedef enum logic [1:0] {
    RPB_IDLE    = 2'd0,
    RPB_REQ     = 2'd1,
    RPB_WAIT_RD = 2'd2
  } rpb_state_e;

  // Bit order matches err_status: [2]=timeout, [1]=overflow, [0]=conflict.
  typedef struct packed {
    logic timeout;
    logic overflow;
    logic conflict;
  } rpb_err_t;

endpackage

// File: rtl/ram_port_bridge_if.sv
// Host RAM-port strobes plus req/gnt memory bus, bundled for the bridge.
interface ram_port_bridge_if
  import ram_port_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = RPB_ADDR_W,
  parameter int unsigned DATA_W = RPB_DATA_W
);

  logic              ram_read_enable;
  logic              ram_write_enable;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] data_to_ram;
  logic [DATA_W-1:0] data_from_ram;
  logic              data_valid;
  logic              STOP;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [ERR_W-1:0]  err_status;

  // Bridge view.
  modport slave (
    input  ram_read_enable, ram_write_enable, ram_address, data_to_ram,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output data_from_ram, data_valid, STOP,
    output mem_req, mem_we, mem_addr, mem_wdata, err_status
  );

  // Environment view: DMA host plus memory.
  modport master (
    output ram_read_enable, ram_write_enable, ram_address, data_to_ram,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  data_from_ram, data_valid, STOP,
    input  mem_req, mem_we, mem_addr, mem_wdata, err_status
  );

endinterface

// File: rtl/ram_port_bridge_cmd_fifo.sv
// Synchronous show-ahead command FIFO; full/empty are registered flags.
module ram_cmd_fifo #(
  parameter int unsigned WIDTH = 97,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     rst_L,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout_c,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_push      = i_push & ~r_full;
  assign w_pop       = i_pop & ~r_empty;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Storage needs no reset; only pointers and flags define validity.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
      if (w_pop)  r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_dout_c = r_mem[r_rd_ptr];
  assign o_full   = r_full;
  assign o_empty  = r_empty;
  assign o_count  = r_count;

endmodule

// File: rtl/ram_port_bridge.sv
// Queues DMA RAM-port strobes and replays them in order as req/gnt memory
// transactions, returning read data and raising STOP as back-pressure.
module ram_port_bridge
  import ram_port_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = RPB_ADDR_W,
  parameter int unsigned DATA_W  = RPB_DATA_W,
  parameter int unsigned DEPTH   = RPB_DEPTH,
  parameter int unsigned TIMEOUT = RPB_TIMEOUT
) (
  input  logic             CLK,
  input  logic             rst_L,
  ram_port_bridge_if.slave bus
);

  localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

  rpb_state_e        r_state;
  rpb_state_e        w_state_nxt;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_data_valid;
  logic              r_stop;
  logic [TMO_W-1:0]  r_tmo_cnt;
  rpb_err_t          r_err;

  logic               w_conflict;
  logic               w_strobe;
  logic               w_push;
  logic               w_overflow;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_tmo_hit;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [ENTRY_W-1:0] w_din;
  logic [ENTRY_W-1:0] w_head;
  logic               w_head_we;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_wdata;

  logic               w_mem_req_nxt;
  logic               w_mem_we_nxt;
  logic [ADDR_W-1:0]  w_mem_addr_nxt;
  logic [DATA_W-1:0]  w_mem_wdata_nxt;
  logic [DATA_W-1:0]  w_rdata_nxt;
  logic               w_data_valid_nxt;
  logic [TMO_W-1:0]   w_tmo_cnt_nxt;
  logic               w_tmo_err;

  // Host side: exactly one strobe enqueues; both at once is a conflict.
  assign w_conflict  = bus.ram_read_enable & bus.ram_write_enable;
  assign w_strobe    = bus.ram_read_enable ^ bus.ram_write_enable;
  assign w_push      = w_strobe & ~w_full;
  assign w_overflow  = w_strobe & w_full;
  assign w_din       = {bus.ram_write_enable, bus.ram_address, bus.data_to_ram};
  assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign w_head_we    = w_head[ENTRY_W-1];
  assign w_head_addr  = w_head[ENTRY_W-2 -: ADDR_W];
  assign w_head_wdata = w_head[DATA_W-1:0];
  assign w_tmo_hit    = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

  ram_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .CLK      (CLK),
    .rst_L    (rst_L),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_din    (w_din),
    .o_dout_c (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      r_state <= RPB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RPB_IDLE: begin
        if (!w_empty) w_state_nxt = RPB_REQ;
      end
      RPB_REQ: begin
        if (bus.mem_gnt) begin
          if (!r_mem_we)    w_state_nxt = RPB_WAIT_RD;
          else if (w_empty) w_state_nxt = RPB_IDLE;
        end
      end
      RPB_WAIT_RD: begin
        if (bus.mem_rvalid || w_tmo_hit) w_state_nxt = RPB_IDLE;
      end
      default: w_state_nxt = RPB_IDLE;
    endcase
  end

  // Next values of the registered bus outputs; a granted write chains the
  // next queued command without dropping mem_req.
  always_comb begin
    w_pop            = 1'b0;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_rdata_nxt      = r_rdata;
    w_data_valid_nxt = 1'b0;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_tmo_err        = 1'b0;
    unique case (r_state)
      RPB_IDLE: begin
        w_pop = ~w_empty;
      end
      RPB_REQ: begin
        if (bus.mem_gnt) begin
          if (r_mem_we) begin
            w_pop         = ~w_empty;
            w_mem_req_nxt = 1'b0;
          end else begin
            w_mem_req_nxt = 1'b0;
            w_tmo_cnt_nxt = '0;
          end
        end
      end
      RPB_WAIT_RD: begin
        if (bus.mem_rvalid) begin
          w_rdata_nxt      = bus.mem_rdata;
          w_data_valid_nxt = 1'b1;
        end else if (w_tmo_hit) begin
          w_tmo_err = 1'b1;
        end else begin
          w_tmo_cnt_nxt = TMO_W'(r_tmo_cnt + 1'b1);
        end
      end
      default: ;
    endcase
    if (w_pop) begin
      w_mem_req_nxt   = 1'b1;
      w_mem_we_nxt    = w_head_we;
      w_mem_addr_nxt  = w_head_addr;
      w_mem_wdata_nxt = w_head_wdata;
    end
  end

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata      <= '0;
      r_data_valid <= 1'b0;
      r_stop       <= 1'b0;
      r_tmo_cnt    <= '0;
      r_err        <= '0;
    end else begin
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_rdata      <= w_rdata_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      // One slot of headroom covers the DMA's one-cycle reaction to STOP.
      r_stop       <= (w_count_nxt >= CNT_W'(DEPTH - 1));
      r_err.timeout  <= r_err.timeout  | w_tmo_err;
      r_err.overflow <= r_err.overflow | w_overflow;
      r_err.conflict <= r_err.conflict | w_conflict;
    end
  end

  assign bus.mem_req       = r_mem_req;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.data_from_ram = r_rdata;
  assign bus.data_valid    = r_data_valid;
  assign bus.STOP          = r_stop;
  assign bus.err_status    = r_err;

endmodule

// File: tb/tb_ram_port_bridge.sv
// Randomized bench for ram_port_bridge against a queue-based transaction model.
module tb_ram_port_bridge;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 255;

  localparam int P_NONE   = 0;
  localparam int P_ISSUED = 1;
  localparam int P_AWAIT  = 2;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  logic CLK   = 1'b0;
  logic rst_L = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  // Model: commands waiting in the queue, the one on the bus, and its phase.
  cmd_t        q[$];
  cmd_t        cur;
  int          phase;
  int          waited;
  logic              exp_req;
  logic              exp_dv;
  logic              exp_stop;
  logic [DATA_W-1:0] exp_rdata;
  logic [2:0]        exp_err;

  always #5 CLK = ~CLK;

  ram_port_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK   (CLK),
    .rst_L (rst_L),
    .bus   (bus)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    cur       = '{we: 1'b0, addr: '0, wdata: '0};
    phase     = P_NONE;
    waited    = 0;
    exp_req   = 1'b0;
    exp_dv    = 1'b0;
    exp_stop  = 1'b0;
    exp_rdata = '0;
    exp_err   = 3'b000;
  endfunction

  // Advance the model across one clock edge using the inputs now on the bus.
  function automatic void model_eval();
    logic rd   = bus.ram_read_enable;
    logic wr   = bus.ram_write_enable;
    bit   full = (q.size() == DEPTH);
    bit   have = (q.size() != 0);
    bit   take = 1'b0;
    cmd_t nc;
    exp_dv = 1'b0;
    case (phase)
      P_NONE: take = have;
      P_ISSUED: begin
        if (bus.mem_gnt) begin
          if (cur.we) begin
            take = have;
            if (!have) begin
              phase   = P_NONE;
              exp_req = 1'b0;
            end
          end else begin
            phase   = P_AWAIT;
            waited  = 0;
            exp_req = 1'b0;
          end
        end
      end
      P_AWAIT: begin
        if (bus.mem_rvalid) begin
          exp_dv    = 1'b1;
          exp_rdata = bus.mem_rdata;
          phase     = P_NONE;
        end else begin
          waited++;
          if (waited == TIMEOUT) begin
            exp_err[2] = 1'b1;
            phase      = P_NONE;
          end
        end
      end
      default: ;
    endcase
    if (take) begin
      cur     = q.pop_front();
      phase   = P_ISSUED;
      exp_req = 1'b1;
    end
    if (rd && wr) begin
      exp_err[0] = 1'b1;
    end else if (rd || wr) begin
      if (full) begin
        exp_err[1] = 1'b1;
      end else begin
        nc.we    = wr;
        nc.addr  = bus.ram_address;
        nc.wdata = bus.data_to_ram;
        q.push_back(nc);
      end
    end
    exp_stop = (q.size() >= DEPTH - 1);
  endfunction

  task automatic check_outputs();
    chk_eq("mem_req",    64'(bus.mem_req),       64'(exp_req));
    chk_eq("stop",       64'(bus.STOP),          64'(exp_stop));
    chk_eq("data_valid", 64'(bus.data_valid),    64'(exp_dv));
    chk_eq("rdata",      64'(bus.data_from_ram), 64'(exp_rdata));
    chk_eq("err_status", 64'(bus.err_status),    64'(exp_err));
    if (exp_req) begin
      chk_eq("mem_we",    64'(bus.mem_we),    64'(cur.we));
      chk_eq("mem_addr",  bus.mem_addr,       cur.addr);
      chk_eq("mem_wdata", 64'(bus.mem_wdata), 64'(cur.wdata));
    end
  endtask

  // One clock: apply inputs, predict, then sample just after the edge.
  task automatic cyc(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wd, input logic gnt, input logic rv,
                     input logic [DATA_W-1:0] rdat);
    bus.ram_read_enable  = rd;
    bus.ram_write_enable = wr;
    bus.ram_address      = addr;
    bus.data_to_ram      = wd;
    bus.mem_gnt          = gnt;
    bus.mem_rvalid       = rv;
    bus.mem_rdata        = rdat;
    model_eval();
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic gnt);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, '0, '0, gnt,
          (phase == P_AWAIT) && ($urandom_range(0, 99) < 50), DATA_W'($urandom));
    end
  endtask

  task automatic do_reset();
    rst_L = 1'b0;
    bus.ram_read_enable  = 1'b0;
    bus.ram_write_enable = 1'b0;
    bus.ram_address      = '0;
    bus.data_to_ram      = '0;
    bus.mem_gnt          = 1'b0;
    bus.mem_rvalid       = 1'b0;
    bus.mem_rdata        = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk_eq("rst_mem_req", 64'(bus.mem_req),       64'd0);
    chk_eq("rst_stop",    64'(bus.STOP),          64'd0);
    chk_eq("rst_dv",      64'(bus.data_valid),    64'd0);
    chk_eq("rst_rdata",   64'(bus.data_from_ram), 64'd0);
    chk_eq("rst_err",     64'(bus.err_status),    64'd0);
    @(negedge CLK);
    rst_L = 1'b1;
  endtask

  initial begin
    logic r_rd;
    logic r_wr;
    int   r;

    do_reset();

    // Conflicting strobes enqueue nothing.
    cyc(1'b1, 1'b1, 64'h3000, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
    idle(4, 1'b1);

    // Single write with immediate grant.
    cyc(1'b0, 1'b1, 64'h1000, 32'hA5A5_A5A5, 1'b1, 1'b0, '0);
    idle(4, 1'b1);

    // Read with a late grant and late data.
    cyc(1'b1, 1'b0, 64'h2000, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h1234_5678);
    idle(3, 1'b0);

    // Back-pressure: stalled bus, strobes until the queue overflows.
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, 64'h4000 + 64'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 1'b0, '0);
    end
    idle(3, 1'b0);
    idle(20, 1'b1);

    // Randomized traffic with a random memory responder.
    for (int i = 0; i < 3000; i++) begin
      r    = int'($urandom_range(0, 99));
      r_wr = (r < 25) || (r == 99);
      r_rd = ((r >= 25) && (r < 45)) || (r == 99);
      cyc(r_rd, r_wr, {$urandom, $urandom}, DATA_W'($urandom),
          1'($urandom_range(0, 1)),
          (phase == P_AWAIT) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 10),
          DATA_W'($urandom));
    end
    idle(30, 1'b1);

    // Read abandoned after the timeout; the queued write must still issue.
    cyc(1'b1, 1'b0, 64'h5000, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 64'h6000, 32'h0BAD_F00D, 1'b1, 1'b0, '0);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);

    // Asynchronous reset while a request is pending and STOP is up.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 64'h7000 + 64'(i * 4), 32'h7700_0000 + 32'(i), 1'b0, 1'b0, '0);
    end
    idle(2, 1'b0);
    chk_eq("pre_rst_req",  64'(bus.mem_req), 64'd1);
    chk_eq("pre_rst_stop", 64'(bus.STOP),    64'd1);
    rst_L = 1'b0;
    #1;
    chk_eq("async_rst_req",  64'(bus.mem_req),    64'd0);
    chk_eq("async_rst_stop", 64'(bus.STOP),       64'd0);
    chk_eq("async_rst_dv",   64'(bus.data_valid), 64'd0);
    model_reset();
    @(negedge CLK);
    rst_L = 1'b1;
    idle(5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
